head_and_tail_remove: RTL and testbench

- Egress counterpart of the flag-adding GMII write path in the TSMP agent.
- Pops 9-bit words from a show-ahead (FWFT) FIFO in which bit[8]=1 marks the head byte and the tail byte of each frame.
- Strips the flag and regenerates a continuous GMII-style byte stream with a data-valid strobe and an enforced inter-frame gap.
- Detects underrun, over-length and headless data, and resynchronises on the next tail.

---
 rtl/head_and_tail_remove.sv | 124 ++++++++++++
 tb/tb_head_and_tail_remove.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/head_and_tail_remove.sv
// Egress side of the flagged GMII FIFO path: strips the head/tail flag from
// FWFT FIFO words and replays each frame as a gap-separated byte stream.
module head_and_tail_remove #(
  parameter int MAX_LEN    = 2047,
  parameter int IFG_CYCLES = 12,
  parameter int CNT_W      = 12
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [8:0] iv_fifo_rdata,
  input  logic       i_fifo_empty,
  output logic       o_fifo_rd,
  output logic [7:0] ov_data,
  output logic       o_data_wr,
  output logic       o_underrun_pulse,
  output logic       o_overlen_pulse,
  output logic       o_headless_pulse
);

  localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'(IFG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE_S,
    TRANS_S,
    DISCARD_S,
    IFG_S
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IFG_W-1:0] ifg_cnt, ifg_cnt_nxt;
  logic             rd, emit, underrun, overlen, headless;
  logic             flag;

  assign flag = iv_fifo_rdata[8];

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ifg_cnt_nxt = ifg_cnt;
    rd          = 1'b0;
    emit        = 1'b0;
    underrun    = 1'b0;
    overlen     = 1'b0;
    headless    = 1'b0;
    unique case (state)
      IDLE_S: begin
        if (!i_fifo_empty) begin
          rd = 1'b1;
          if (flag) begin
            emit      = 1'b1;
            cnt_nxt   = CNT_W'(1);
            state_nxt = TRANS_S;
          end else begin
            headless = 1'b1;
          end
        end
      end
      TRANS_S: begin
        // Empty wins over the length limit so only one error fires per cycle.
        if (i_fifo_empty) begin
          underrun  = 1'b1;
          state_nxt = DISCARD_S;
        end else if (cnt == CNT_MAX) begin
          overlen   = 1'b1;
          state_nxt = DISCARD_S;
        end else begin
          rd      = 1'b1;
          emit    = 1'b1;
          cnt_nxt = cnt + CNT_W'(1);
          if (flag) begin
            ifg_cnt_nxt = IFG_LOAD;
            state_nxt   = IFG_S;
          end
        end
      end
      DISCARD_S: begin
        if (!i_fifo_empty) begin
          rd = 1'b1;
          if (flag) begin
            ifg_cnt_nxt = IFG_LOAD;
            state_nxt   = IFG_S;
          end
        end
      end
      IFG_S: begin
        if (ifg_cnt == '0) begin
          state_nxt = IDLE_S;
        end else begin
          ifg_cnt_nxt = ifg_cnt - IFG_W'(1);
        end
      end
      default: state_nxt = IDLE_S;
    endcase
  end

  // Gate with reset so nothing is popped while the block is held in reset.
  assign o_fifo_rd = rd & i_rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= IDLE_S;
      cnt              <= '0;
      ifg_cnt          <= '0;
      ov_data          <= '0;
      o_data_wr        <= 1'b0;
      o_underrun_pulse <= 1'b0;
      o_overlen_pulse  <= 1'b0;
      o_headless_pulse <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      ifg_cnt          <= ifg_cnt_nxt;
      o_data_wr        <= emit;
      o_underrun_pulse <= underrun;
      o_overlen_pulse  <= overlen;
      o_headless_pulse <= headless;
      if (emit) ov_data <= iv_fifo_rdata[7:0];
    end
  end

endmodule

// File: tb/tb_head_and_tail_remove.sv
// Bench for head_and_tail_remove: frame-level timeline model driven by a
// bench-side FWFT FIFO, with directed, reset and randomized scenarios.
module tb_head_and_tail_remove;

  localparam int MAX_LEN = 64;
  localparam int IFG     = 12;
  localparam int CNT_W   = 7;
  localparam int TMAX    = 4096;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [8:0] iv_fifo_rdata = '0;
  logic       i_fifo_empty = 1'b1;
  logic       o_fifo_rd;
  logic [7:0] ov_data;
  logic       o_data_wr;
  logic       o_underrun_pulse;
  logic       o_overlen_pulse;
  logic       o_headless_pulse;

  head_and_tail_remove #(
    .MAX_LEN   (MAX_LEN),
    .IFG_CYCLES(IFG),
    .CNT_W     (CNT_W)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .iv_fifo_rdata   (iv_fifo_rdata),
    .i_fifo_empty    (i_fifo_empty),
    .o_fifo_rd       (o_fifo_rd),
    .ov_data         (ov_data),
    .o_data_wr       (o_data_wr),
    .o_underrun_pulse(o_underrun_pulse),
    .o_overlen_pulse (o_overlen_pulse),
    .o_headless_pulse(o_headless_pulse)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  logic [8:0] fq[$];
  logic [8:0] sw[$];
  int         popped;
  int         gap_rem;

  // Expected outputs indexed by clock edge count within a scenario.
  logic       exp_wr[TMAX];
  logic [7:0] exp_d[TMAX];
  logic       exp_ur[TMAX];
  logic       exp_ol[TMAX];
  logic       exp_hl[TMAX];
  int         n_edges;

  // Frame-level timeline: a word popped at edge e shows at edge e; frames
  // end at their tail edge T and the next pop is allowed at T+IFG+1.
  // The FIFO is empty for gl edges after ga words have been popped.
  function automatic void build_model(input logic [8:0] w[$], input int ga, input int gl);
    int e, i, j, len, k, t_end;
    for (int t = 0; t < TMAX; t++) begin
      exp_wr[t] = 1'b0; exp_d[t] = '0; exp_ur[t] = 1'b0; exp_ol[t] = 1'b0; exp_hl[t] = 1'b0;
    end
    e = 1;
    i = 0;
    while (i < w.size()) begin
      if (!w[i][8]) begin
        exp_hl[e] = 1'b1;
        e++;
        i++;
      end else begin
        j = i + 1;
        while (j < w.size() && !w[j][8]) j++;
        len = j - i + 1;
        k = (ga > i && ga <= j) ? ga - i : len;
        if (k < len && k <= MAX_LEN) begin
          for (int b = 0; b < k; b++) begin exp_wr[e+b] = 1'b1; exp_d[e+b] = w[i+b][7:0]; end
          exp_ur[e+k] = 1'b1;
          t_end = e + k + gl + (len - k) - 1;
        end else if (len > MAX_LEN) begin
          for (int b = 0; b < MAX_LEN; b++) begin exp_wr[e+b] = 1'b1; exp_d[e+b] = w[i+b][7:0]; end
          exp_ol[e+MAX_LEN] = 1'b1;
          t_end = e + len + ((k < len) ? gl : 0);
        end else begin
          for (int b = 0; b < len; b++) begin exp_wr[e+b] = 1'b1; exp_d[e+b] = w[i+b][7:0]; end
          t_end = e + len - 1;
        end
        e = t_end + IFG + 1;
        i = j + 1;
      end
    end
    n_edges = e + 1;
  endfunction

  task automatic pin(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  task automatic drive_inputs();
    if (fq.size() == 0 || gap_rem > 0) begin
      i_fifo_empty  = 1'b1;
      iv_fifo_rdata = '0;
    end else begin
      i_fifo_empty  = 1'b0;
      iv_fifo_rdata = fq[0];
    end
  endtask

  task automatic check_cycle(input int t, input string name);
    logic [3:0] act, req;
    act = {o_data_wr, o_underrun_pulse, o_overlen_pulse, o_headless_pulse};
    req = {exp_wr[t], exp_ur[t], exp_ol[t], exp_hl[t]};
    checks++;
    if (act !== req || (exp_wr[t] && ov_data !== exp_d[t])) begin
      errors++;
      $display("FAIL %s t=%0d wr/ur/ol/hl=%b data=%h required %b data=%h",
               name, t, act, ov_data, req, exp_d[t]);
    end
    checks++;
    if (o_fifo_rd && i_fifo_empty) begin
      errors++;
      $display("FAIL %s_rd_while_empty t=%0d o_fifo_rd=1 required 0", name, t);
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns in the same phase.
  task automatic run_scenario(input logic [8:0] w[$], input int ga, input int gl, input string name);
    logic rd;
    build_model(w, ga, gl);
    fq = w;
    popped = 0;
    gap_rem = 0;
    for (int t = 0; t <= n_edges; t++) begin
      drive_inputs();
      @(negedge i_clk);
      check_cycle(t, name);
      rd = o_fifo_rd;
      @(posedge i_clk);
      #1;
      if (gap_rem > 0) gap_rem--;
      if (rd && fq.size() > 0) begin
        void'(fq.pop_front());
        popped++;
        if (popped == ga) gap_rem = gl;
      end
    end
    pin({name, "_fifo_drained"}, fq.size(), 0);
    drive_inputs();
  endtask

  task automatic add_frame(input int len, input logic [7:0] base);
    for (int b = 0; b < len; b++)
      sw.push_back({(b == 0 || b == len - 1), 8'(base + b)});
  endtask

  task automatic add_frame_rand(input int len);
    for (int b = 0; b < len; b++)
      sw.push_back({(b == 0 || b == len - 1), 8'($urandom)});
  endtask

  function automatic int count_wr();
    int n = 0;
    for (int t = 0; t < TMAX; t++) if (exp_wr[t]) n++;
    return n;
  endfunction

  initial begin
    logic rd;
    repeat (3) @(posedge i_clk);
    #1;
    pin("reset_data_wr", int'(o_data_wr), 0);
    pin("reset_fifo_rd", int'(o_fifo_rd), 0);
    pin("reset_pulses", int'({o_underrun_pulse, o_overlen_pulse, o_headless_pulse}), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    sw = {};
    add_frame(MAX_LEN, 8'h00);
    run_scenario(sw, 0, 0, "max_len_frame");
    pin("m_max_len_count", count_wr(), MAX_LEN);
    pin("m_max_len_last", int'(exp_d[64]), 8'h3F);

    sw = {9'h1AA, 9'h1BB, 9'h1CC, 9'h1DD};
    run_scenario(sw, 0, 0, "back_to_back");
    pin("m_b2b_bb", int'(exp_d[2]), 8'hBB);
    pin("m_b2b_gap_end", int'(exp_wr[14]), 0);
    pin("m_b2b_cc", int'({exp_wr[15], exp_d[15]}), 9'h1CC);
    pin("m_b2b_dd", int'({exp_wr[16], exp_d[16]}), 9'h1DD);

    sw = {};
    add_frame(60, 8'h40);
    add_frame(4, 8'hE0);
    run_scenario(sw, 10, 5, "underrun");
    pin("m_ur_last_byte", int'(exp_wr[10]), 1);
    pin("m_ur_pulse", int'({exp_wr[11], exp_ur[11]}), 1);
    pin("m_ur_next_gap", int'(exp_wr[77]), 0);
    pin("m_ur_next", int'({exp_wr[78], exp_d[78]}), 9'h1E0);

    sw = {};
    add_frame(MAX_LEN + 4, 8'h80);
    add_frame(3, 8'h10);
    run_scenario(sw, 0, 0, "overlen");
    pin("m_ol_count_first", int'(exp_wr[64]), 1);
    pin("m_ol_pulse", int'({exp_wr[65], exp_ol[65]}), 1);
    pin("m_ol_next", int'({exp_wr[82], exp_d[82]}), 9'h110);

    sw = {9'h011, 9'h022};
    add_frame(5, 8'h30);
    run_scenario(sw, 0, 0, "headless");
    pin("m_hl_pulses", int'({exp_hl[1], exp_hl[2], exp_hl[3]}), 3'b110);
    pin("m_hl_frame", int'({exp_wr[3], exp_d[3]}), 9'h130);

    // Reset in the middle of a frame.
    sw = {};
    add_frame(20, 8'h50);
    fq = sw;
    popped = 0;
    gap_rem = 0;
    for (int t = 0; t < 5; t++) begin
      drive_inputs();
      @(negedge i_clk);
      rd = o_fifo_rd;
      @(posedge i_clk);
      #1;
      if (rd) begin void'(fq.pop_front()); popped++; end
    end
    pin("rst_pre_byte", int'({o_data_wr, ov_data}), 9'h154);
    drive_inputs();
    #2;
    i_rst_n = 1'b0;
    #1;
    pin("rst_async_wr", int'(o_data_wr), 0);
    pin("rst_async_data", int'(ov_data), 0);
    for (int t = 0; t < 2; t++) begin
      @(negedge i_clk);
      pin("rst_no_pop", int'(o_fifo_rd), 0);
    end
    i_fifo_empty = 1'b1;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    sw = fq;
    sw.push_back(9'h15A);
    add_frame(3, 8'hC1);
    run_scenario(sw, 0, 0, "post_reset");
    pin("m_rst_headless", int'({exp_hl[14], exp_hl[15]}), 2'b10);
    pin("m_rst_head", int'({exp_wr[15], exp_d[15]}), 9'h163);

    for (int s = 0; s < 25; s++) begin
      int nf, ga, gl, len, kmax;
      sw = {};
      ga = 0;
      gl = 0;
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        if ($urandom_range(0, 3) == 0) sw.push_back({1'b0, 8'($urandom)});
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(MAX_LEN - 1, MAX_LEN + 6)
                                          : $urandom_range(2, 20);
        if (ga == 0 && $urandom_range(0, 2) == 0) begin
          kmax = (len - 1 < MAX_LEN) ? len - 1 : MAX_LEN;
          gl = $urandom_range(1, 6);
          ga = sw.size() + $urandom_range(1, kmax);
        end
        add_frame_rand(len);
      end
      run_scenario(sw, ga, gl, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
